// File: rtl/vga_timing_monitor.sv
// Purpose : measures VGA raster timing, checksums the active picture and reports lock/error status.
// Latency : frame outputs and the frame_done_o pulse update two clocks after the input vsync rising edge.
// Backpressure: none; a passive observer that samples its inputs on every pixel clock.
//
// Ports:
//   clk25m, reset      pixel clock, asynchronous active-high reset
//   hsync_i, vsync_i   active-high syncs from the scan converter
//   blank_i, rgb_i     blanking flag and {B[1:0],G[2:0],R[2:0]} pixel
//   h_total_o, h_active_o, v_total_o, v_active_o, frame_crc_o, frame_count_o
//                      measurements of the last completed frame
//   frame_done_o       one-cycle pulse whenever the measurement outputs update
//   locked_o, err_o    timing stable / sticky counter-saturation error
module vga_timing_monitor #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk25m,
  input  logic        reset,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        blank_i,
  input  logic [7:0]  rgb_i,
  output logic [10:0] h_total_o,
  output logic [10:0] h_active_o,
  output logic [9:0]  v_total_o,
  output logic [9:0]  v_active_o,
  output logic [15:0] frame_crc_o,
  output logic [15:0] frame_count_o,
  output logic        frame_done_o,
  output logic        locked_o,
  output logic        err_o
);

  localparam logic [10:0] HMAX    = 11'd2047;
  localparam logic [9:0]  VMAX    = 10'd1023;
  localparam logic [3:0]  SMAX    = 4'd15;
  localparam logic [3:0]  LOCK_TH = 4'(LOCK_FRAMES);

  typedef enum logic {WAIT_VS, MEASURE} state_t;

  state_t      state_q, state_d;

  // input sampling (s1) and sync history (s2)
  logic        hs_s1, vs_s1, bl_s1, hs_s2, vs_s2;
  logic [7:0]  rgb_s1;

  // running measurements of the frame in progress
  logic [10:0] hcnt, acnt, line_len, last_act;
  logic [9:0]  vcnt, vact;
  logic [15:0] crc;
  logic [3:0]  stable;
  logic        have_prev;

  logic        hs_edge, vs_edge, capture, match, err_set;
  logic [10:0] hcnt_nxt, acnt_nxt, line_len_cl, last_act_cl;
  logic [9:0]  vcnt_cl, vact_cl;
  logic [15:0] crc_base, crc_nxt;
  logic [3:0]  stable_nxt;

  // CRC-16-CCITT, polynomial 0x1021, one byte MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign hs_edge = hs_s1 & ~hs_s2;
  assign vs_edge = vs_s1 & ~vs_s2;

  // The sync-edge clock itself is the first clock of the new line.
  assign hcnt_nxt = hs_edge ? 11'd1 : ((hcnt == HMAX) ? hcnt : hcnt + 11'd1);
  assign acnt_nxt = hs_edge ? {10'd0, ~bl_s1}
                            : ((bl_s1 || acnt == HMAX) ? acnt : acnt + 11'd1);

  // Close the line before the frame is evaluated, so a line ending on the
  // vsync edge belongs to the frame that is completing.
  assign line_len_cl = hs_edge ? hcnt : line_len;
  assign vcnt_cl     = hs_edge ? ((vcnt == VMAX) ? vcnt : vcnt + 10'd1) : vcnt;
  assign vact_cl     = (hs_edge && acnt != 11'd0) ? ((vact == VMAX) ? vact : vact + 10'd1) : vact;
  // The lines just before vsync are vertical blanking, so h_active reports
  // the last line of the frame that actually carried picture.
  assign last_act_cl = (hs_edge && acnt != 11'd0) ? acnt : last_act;

  assign crc_base = vs_edge ? 16'hFFFF : crc;
  assign crc_nxt  = bl_s1 ? crc_base : crc16_byte(crc_base, rgb_s1);

  assign err_set = ~err_o & ((hcnt_nxt == HMAX) | (vcnt_cl == VMAX));

  // CRC is deliberately left out of the lock comparison.
  assign match = have_prev &&
                 ({line_len_cl, last_act_cl, vcnt_cl, vact_cl} ==
                  {h_total_o, h_active_o, v_total_o, v_active_o});

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    stable_nxt = stable;
    case (state_q)
      WAIT_VS: if (vs_edge) state_d = MEASURE;
      MEASURE: capture = vs_edge;
      default: state_d = WAIT_VS;
    endcase
    if (err_set)
      stable_nxt = 4'd0;
    else if (capture)
      stable_nxt = match ? ((stable == SMAX) ? stable : stable + 4'd1) : 4'd0;
  end

  always_ff @(posedge clk25m or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_VS;
      hs_s1         <= 1'b0;
      vs_s1         <= 1'b0;
      bl_s1         <= 1'b0;
      rgb_s1        <= 8'd0;
      hs_s2         <= 1'b0;
      vs_s2         <= 1'b0;
      hcnt          <= 11'd0;
      acnt          <= 11'd0;
      line_len      <= 11'd0;
      last_act      <= 11'd0;
      vcnt          <= 10'd0;
      vact          <= 10'd0;
      crc           <= 16'hFFFF;
      stable        <= 4'd0;
      have_prev     <= 1'b0;
      h_total_o     <= 11'd0;
      h_active_o    <= 11'd0;
      v_total_o     <= 10'd0;
      v_active_o    <= 10'd0;
      frame_crc_o   <= 16'd0;
      frame_count_o <= 16'd0;
      frame_done_o  <= 1'b0;
      locked_o      <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_s1        <= hsync_i;
      vs_s1        <= vsync_i;
      bl_s1        <= blank_i;
      rgb_s1       <= rgb_i;
      hs_s2        <= hs_s1;
      vs_s2        <= vs_s1;
      hcnt         <= hcnt_nxt;
      acnt         <= acnt_nxt;
      line_len     <= line_len_cl;
      vcnt         <= vs_edge ? 10'd0 : vcnt_cl;
      vact         <= vs_edge ? 10'd0 : vact_cl;
      last_act     <= vs_edge ? 11'd0 : last_act_cl;
      crc          <= crc_nxt;
      err_o        <= err_o | err_set;
      stable       <= stable_nxt;
      locked_o     <= (stable_nxt >= LOCK_TH);
      frame_done_o <= capture;
      if (capture) begin
        h_total_o     <= line_len_cl;
        h_active_o    <= last_act_cl;
        v_total_o     <= vcnt_cl;
        v_active_o    <= vact_cl;
        frame_crc_o   <= crc;
        frame_count_o <= frame_count_o + 16'd1;
        have_prev     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Purpose : directed self-checking bench for vga_timing_monitor using scaled raster timings.
// Latency : checks frame_done_o two clocks after the vsync input edge.
// Backpressure: not applicable; stimulus streams one pixel per clock.
module tb_vga_timing_monitor;

  logic        clk25m = 1'b0;
  logic        reset;
  logic        hsync_i, vsync_i, blank_i;
  logic [7:0]  rgb_i;
  logic [10:0] h_total_o, h_active_o;
  logic [9:0]  v_total_o, v_active_o;
  logic [15:0] frame_crc_o, frame_count_o;
  logic        frame_done_o, locked_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #20 clk25m = ~clk25m;

  vga_timing_monitor #(.LOCK_FRAMES(2)) dut (
    .clk25m(clk25m), .reset(reset),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .rgb_i(rgb_i),
    .h_total_o(h_total_o), .h_active_o(h_active_o),
    .v_total_o(v_total_o), .v_active_o(v_active_o),
    .frame_crc_o(frame_crc_o), .frame_count_o(frame_count_o),
    .frame_done_o(frame_done_o), .locked_o(locked_o), .err_o(err_o)
  );

  // frame_done_o monitor: counts pulses and snapshots the outputs on each one
  int   cyc = 0, vs_cyc = 0, done_lat = 0, done_cnt = 0;
  logic vs_prev = 1'b0;
  int   s_htot = 0, s_hact = 0, s_vtot = 0, s_vact = 0, s_crc = 0, s_cnt = 0, s_lock = 0;

  always @(negedge clk25m) begin
    cyc     <= cyc + 1;
    vs_prev <= vsync_i;
    if (vsync_i && !vs_prev) vs_cyc <= cyc;
    if (frame_done_o) begin
      done_cnt <= done_cnt + 1;
      done_lat <= cyc - vs_cyc;
      s_htot   <= 32'(h_total_o);
      s_hact   <= 32'(h_active_o);
      s_vtot   <= 32'(v_total_o);
      s_vact   <= 32'(v_active_o);
      s_crc    <= 32'(frame_crc_o);
      s_cnt    <= 32'(frame_count_o);
      s_lock   <= 32'(locked_o);
    end
  end

  // reference CRC-16-CCITT (byte folded into the high byte, then 8 shifts)
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk25m); #1;
      hsync_i = 1'b0; vsync_i = 1'b0; blank_i = 1'b1; rgb_i = 8'h5A;
    end
  endtask

  // One raster frame: ht clocks x vt lines, ha x va active at the top-left,
  // hsync after the active part, vsync rising together with hsync on the last line.
  task automatic run_frame(input int ht, input int ha, input int vt, input int va,
                           input int stop, input int px, input int py, input bit pat,
                           output logic [15:0] crc_exp);
    int hs0, hw;
    logic [15:0] c;
    c   = 16'hFFFF;
    hs0 = ha + 2;
    hw  = (ht - ha) / 2;
    for (int y = 0; y < stop; y++) begin
      for (int x = 0; x < ht; x++) begin
        @(posedge clk25m); #1;
        hsync_i = (x >= hs0) && (x < hs0 + hw);
        vsync_i = (y == vt - 1) && hsync_i;
        blank_i = !((x < ha) && (y < va));
        if (blank_i)                 rgb_i = 8'hA5;
        else if (x == px && y == py) rgb_i = 8'hFF;
        else if (pat)                rgb_i = 8'(x * 3 + y * 7);
        else                         rgb_i = 8'h00;
        if (!blank_i) c = crc_ref(c, rgb_i);
      end
    end
    crc_exp = c;
  endtask

  task automatic frame_chk(input string tag, input int exp_done, input int ht, input int ha,
                           input int vt, input int va, input int lk, input int fc,
                           input logic [15:0] crc);
    chk({tag, "_done"},  done_cnt, exp_done);
    chk({tag, "_htot"},  s_htot, ht);
    chk({tag, "_hact"},  s_hact, ha);
    chk({tag, "_vtot"},  s_vtot, vt);
    chk({tag, "_vact"},  s_vact, va);
    chk({tag, "_crc"},   s_crc, 32'(crc));
    chk({tag, "_count"}, s_cnt, fc);
    chk({tag, "_lock"},  s_lock, lk);
  endtask

  initial begin
    logic [15:0] c;
    int exp_done;
    int crc_z_obs;
    exp_done = 0;
    reset = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0; blank_i = 1'b1; rgb_i = 8'h00;
    repeat (3) @(posedge clk25m);
    #1;
    chk("rst_htot",  32'(h_total_o), 0);
    chk("rst_vtot",  32'(v_total_o), 0);
    chk("rst_crc",   32'(frame_crc_o), 0);
    chk("rst_count", 32'(frame_count_o), 0);
    chk("rst_done",  32'(frame_done_o), 0);
    chk("rst_lock",  32'(locked_o), 0);
    chk("rst_err",   32'(err_o), 0);
    reset = 1'b0;

    // 800 clocks / 640 active per line; first vsync only arms the monitor
    run_frame(800, 640, 5, 3, 5, -1, -1, 1'b1, c);
    chk("a_wait_no_done", done_cnt, 0);
    for (int f = 1; f <= 4; f++) begin
      run_frame(800, 640, 5, 3, 5, -1, -1, 1'b1, c);
      exp_done++;
      frame_chk($sformatf("a%0d", f), exp_done, 800, 640, 5, 3, (f >= 3) ? 1 : 0, f, c);
    end
    chk("a_done_latency", done_lat, 2);

    // 525 lines with vsync and hsync edges coincident on the last line
    run_frame(16, 8, 525, 480, 525, -1, -1, 1'b1, c);
    exp_done++;
    frame_chk("b525", exp_done, 16, 8, 525, 480, 0, 5, c);

    // lock, one frame with an extra line, relock
    for (int f = 0; f < 3; f++) begin
      run_frame(16, 8, 10, 6, 10, -1, -1, 1'b1, c);
      exp_done++;
      frame_chk($sformatf("c%0d", f), exp_done, 16, 8, 10, 6, (f == 2) ? 1 : 0, 6 + f, c);
    end
    run_frame(16, 8, 11, 6, 11, -1, -1, 1'b1, c);
    exp_done++;
    frame_chk("c_long", exp_done, 16, 8, 11, 6, 0, 9, c);
    for (int f = 0; f < 3; f++) begin
      run_frame(16, 8, 10, 6, 10, -1, -1, 1'b1, c);
      exp_done++;
      frame_chk($sformatf("c_re%0d", f), exp_done, 16, 8, 10, 6, (f == 2) ? 1 : 0, 10 + f, c);
    end

    // all-zero picture, then one pixel set; CRC changes but lock still builds
    run_frame(16, 8, 4, 2, 4, -1, -1, 1'b0, c);
    exp_done++;
    frame_chk("d_zero", exp_done, 16, 8, 4, 2, 0, 13, c);
    crc_z_obs = s_crc;
    run_frame(16, 8, 4, 2, 4, 3, 1, 1'b0, c);
    exp_done++;
    frame_chk("d_pix", exp_done, 16, 8, 4, 2, 0, 14, c);
    chk("d_crc_differs", 32'(s_crc != crc_z_obs), 1);
    run_frame(16, 8, 4, 2, 4, -1, -1, 1'b0, c);
    exp_done++;
    frame_chk("d_zero2", exp_done, 16, 8, 4, 2, 1, 15, c);

    // hsync missing for a long time: saturation sets sticky error
    idle(2000);
    chk("e_err_before_sat", 32'(err_o), 0);
    idle(100);
    chk("e_err_at_sat", 32'(err_o), 1);
    chk("e_lock_cleared", 32'(locked_o), 0);
    run_frame(16, 8, 4, 2, 4, -1, -1, 1'b1, c);
    run_frame(16, 8, 4, 2, 4, -1, -1, 1'b1, c);
    exp_done += 2;
    chk("e_done_recovered", done_cnt, exp_done);
    chk("e_err_sticky", 32'(err_o), 1);

    // reset in the middle of a frame
    run_frame(16, 8, 10, 6, 5, -1, -1, 1'b1, c);
    reset = 1'b1;
    #1;
    chk("f_rst_htot",  32'(h_total_o), 0);
    chk("f_rst_hact",  32'(h_active_o), 0);
    chk("f_rst_vtot",  32'(v_total_o), 0);
    chk("f_rst_vact",  32'(v_active_o), 0);
    chk("f_rst_crc",   32'(frame_crc_o), 0);
    chk("f_rst_count", 32'(frame_count_o), 0);
    chk("f_rst_lock",  32'(locked_o), 0);
    chk("f_rst_err",   32'(err_o), 0);
    idle(3);
    reset = 1'b0;
    run_frame(16, 8, 10, 6, 10, -1, -1, 1'b1, c);
    chk("f_no_done_first_vs", done_cnt, exp_done);
    chk("f_htot_held_zero", 32'(h_total_o), 0);
    run_frame(16, 8, 10, 6, 10, -1, -1, 1'b1, c);
    exp_done++;
    frame_chk("f_after", exp_done, 16, 8, 10, 6, 0, 1, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: number of consecutive matching frames required before locked_o asserts (range 1-15).
REQ-002 SHALL have port clk25m, input, 1: pixel clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port hsync_i, input, 1: VGA horizontal sync from the scan converter, active-high.
REQ-005 SHALL have port vsync_i, input, 1: VGA vertical sync, active-high.
REQ-006 SHALL have port blank_i, input, 1: high outside the active picture.
REQ-007 SHALL have port rgb_i, input, 8: pixel, format {B[1:0],G[2:0],R[2:0]}.
REQ-008 SHALL have port h_total_o, output, 11: clocks per line, from the last completed frame.
REQ-009 SHALL have port h_active_o, output, 11: unblanked clocks in the last line of the last completed frame.
REQ-010 SHALL have port v_total_o, output, 10: lines per frame.
REQ-011 SHALL have port v_active_o, output, 10: lines containing at least one unblanked clock.
REQ-012 SHALL have port frame_crc_o, output, 16: CRC over active pixels of the last completed frame.
REQ-013 SHALL have port frame_count_o, output, 16: number of completed frames, wrapping.
REQ-014 SHALL have port frame_done_o, output, 1: one-cycle pulse when the frame outputs update.
REQ-015 SHALL have port locked_o, output, 1: timing stable.
REQ-016 SHALL have port err_o, output, 1: sticky timing error.

Function
REQ-017 SHALL register hsync_i, vsync_i, blank_i and rgb_i once (stage s1), and keep a second copy of the syncs (s2); leading edge = s1 & ~s2.
REQ-018 SHALL use states WAIT_VS (after reset) and MEASURE; WAIT_VS -> MEASURE on the first vsync leading edge; no frame_done in WAIT_VS.
REQ-019 SHALL run hcnt (11 bits), starting at 1 on each hsync edge and incrementing every clock; on the next hsync edge, hcnt is latched as the line length.
REQ-020 SHALL count active clocks per line (s1 blank low), latch that count on the hsync edge, and clear it.
REQ-021 SHALL count hsync edges (vcnt) and lines with nonzero active count (vact) within the frame.
REQ-022 SHALL compute CRC-16-CCITT (poly 0x1021, MSB first, one byte per active clock) seeded 0xFFFF at each vsync edge.
REQ-023 On a vsync edge in MEASURE, SHALL update all measurement outputs and increment frame_count_o, with frame_done_o high for exactly the following cycle (two clocks after the input sync edge).
REQ-024 SHALL resolve an hsync and vsync edge in the same cycle by closing the line first, so that line is included in the completing frame.
REQ-025 SHALL saturate hcnt at 2047 and vcnt at 1023; reaching either saturation value SHALL set err_o, which stays set until reset.
REQ-026 SHALL compare each new {h_total, h_active, v_total, v_active} with the previous frame's values.
REQ-027 On a match, SHALL increment a stable counter, saturating at 15; locked_o SHALL be 1 while the counter is at least LOCK_FRAMES.
REQ-028 On any mismatch or an err_o set event, SHALL clear the stable counter and deassert locked_o in the same cycle that frame_done_o is asserted.
REQ-029 The first frame after reset SHALL have no predecessor and SHALL count as a mismatch.
REQ-030 SHALL NOT include the CRC in lock comparison.

Reset
REQ-031 reset SHALL asynchronously force all outputs, counters, the CRC (0xFFFF internal), sync history and the stable count to zero, and the state to WAIT_VS.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, the measurement outputs SHALL hold zero until two vsync edges have occurred.

Verification
REQ-033 Standard 640x480 timing (800x525 clocks, 640x480 active) for 4 frames -> frame 1 reports h_total_o=800, h_active_o=640, v_total_o=525 and v_active_o=480, and locked_o=1 from the 3rd frame_done_o onward (LOCK_FRAMES=2).
REQ-034 Locked stream, then one frame with 526 lines -> locked_o=0 on that frame_done_o, and locked_o=1 again two matching frames later.
REQ-035 Active pixels all 0x00, then an identical frame with one pixel set to 0xFF -> frame_crc_o values differ, and each matches a software CRC-16-CCITT model.
REQ-036 hsync held low for 3000 clocks -> err_o=1 from hcnt=2047 onward and stays set after timing recovers, until reset.
REQ-037 reset pulsed at line 200 -> all outputs 0 immediately, no frame_done_o at the next vsync edge, and a valid frame_done_o at the following one.
REQ-038 hsync and vsync leading edges in the same cycle -> v_total_o includes that line (525, not 524).
